// File: rtl/trigger_out_gen_if.sv
// rtl/trigger_out_gen_if.sv - event inputs, host controls and trigger/status outputs of trigger_out_gen
//
// master: host/board side, drives event_in, rise_en, fall_en, holdoff, clear, clear_count
//         and observes ep_trigger, pending, overflow, event_count.
// slave:  trigger_out_gen itself.
// Outputs are fixed at 32 bits so they map straight onto okTriggerOut / WireOut; bits [31:N] are 0.
interface trigger_out_gen_if #(
    parameter int N         = 16,
    parameter int HOLDOFF_W = 8
);
    logic [N-1:0]         event_in;
    logic [N-1:0]         rise_en;
    logic [N-1:0]         fall_en;
    logic [HOLDOFF_W-1:0] holdoff;
    logic [N-1:0]         clear;
    logic                 clear_count;
    logic [31:0]          ep_trigger;
    logic [31:0]          pending;
    logic [31:0]          overflow;
    logic [15:0]          event_count;

    modport master (
        output event_in, rise_en, fall_en, holdoff, clear, clear_count,
        input  ep_trigger, pending, overflow, event_count
    );

    modport slave (
        input  event_in, rise_en, fall_en, holdoff, clear, clear_count,
        output ep_trigger, pending, overflow, event_count
    );
endinterface

// File: rtl/trigger_out_gen.sv
// rtl/trigger_out_gen.sv - level-to-pulse TriggerOut producer with holdoff, sticky status and event counter
//
// Ports:
//   sys_clk  - single clock for all logic (shared with the okTriggerOut endpoint)
//   reset    - asynchronous, active-high; clears all state
//   bus      - trigger_out_gen_if.slave:
//              event_in (async levels), rise_en/fall_en (edge selects), holdoff (window length),
//              clear/clear_count (single-cycle host pulses), ep_trigger (one-cycle pulses),
//              pending/overflow (sticky flags), event_count (saturating tally)
// All outputs come straight from flops.
module trigger_out_gen #(
    parameter int N         = 16,
    parameter int HOLDOFF_W = 8
) (
    input  logic               sys_clk,
    input  logic               reset,
    trigger_out_gen_if.slave   bus
);

    logic [N-1:0]         s1_q, s1_d;
    logic [N-1:0]         s2_q, s2_d;
    logic [N-1:0]         s3_q, s3_d;
    logic [N-1:0]         ep_trigger_q, ep_trigger_d;
    logic [N-1:0]         pending_q, pending_d;
    logic [N-1:0]         overflow_q, overflow_d;
    logic [15:0]          event_count_q, event_count_d;
    logic [HOLDOFF_W-1:0] hc_q [N];
    logic [HOLDOFF_W-1:0] hc_d [N];

    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] det;
    logic [N-1:0] acc;
    logic [5:0]   acc_pop;
    logic [15:0]  count_base;
    logic [16:0]  count_sum;

    always_comb begin
        // s1/s2 form the synchronizer; s3 only remembers the previous synchronized level
        s1_d = bus.event_in;
        s2_d = s1_q;
        s3_d = s2_q;

        rise = s2_q & ~s3_q;
        fall = ~s2_q & s3_q;
        det  = (bus.rise_en & rise) | (bus.fall_en & fall);

        // A running holdoff swallows detections; holdoff is only sampled when an event is accepted
        acc = '0;
        for (int i = 0; i < N; i++) begin
            hc_d[i] = hc_q[i];
            if (hc_q[i] != '0) begin
                hc_d[i] = hc_q[i] - 1'b1;
            end else if (det[i]) begin
                acc[i]  = 1'b1;
                hc_d[i] = bus.holdoff;
            end
        end

        ep_trigger_d = acc;
        // A simultaneous event beats clear for pending, but clear beats the overflow set
        pending_d  = (pending_q & ~bus.clear) | acc;
        overflow_d = (overflow_q | (acc & pending_q)) & ~bus.clear;

        acc_pop = '0;
        for (int i = 0; i < N; i++) begin
            acc_pop = acc_pop + 6'(acc[i]);
        end
        // clear_count still counts events accepted in the same cycle
        count_base    = bus.clear_count ? 16'd0 : event_count_q;
        count_sum     = {1'b0, count_base} + 17'(acc_pop);
        event_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            s1_q          <= '0;
            s2_q          <= '0;
            s3_q          <= '0;
            ep_trigger_q  <= '0;
            pending_q     <= '0;
            overflow_q    <= '0;
            event_count_q <= '0;
            for (int i = 0; i < N; i++) begin
                hc_q[i] <= '0;
            end
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            ep_trigger_q  <= ep_trigger_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            event_count_q <= event_count_d;
            for (int i = 0; i < N; i++) begin
                hc_q[i] <= hc_d[i];
            end
        end
    end

    assign bus.ep_trigger  = 32'(ep_trigger_q);
    assign bus.pending     = 32'(pending_q);
    assign bus.overflow    = 32'(overflow_q);
    assign bus.event_count = event_count_q;

endmodule

// File: tb/tb_trigger_out_gen.sv
// tb/tb_trigger_out_gen.sv - table-driven and sequence checks for trigger_out_gen
module tb_trigger_out_gen;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    trigger_out_gen_if #(.N(16), .HOLDOFF_W(8)) bus ();

    trigger_out_gen #(.N(16), .HOLDOFF_W(8)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] ev;
        logic [15:0] ren;
        logic [15:0] fen;
        logic        clr0;
        logic        cc;
        logic [31:0] ep;
        logic [31:0] pend;
        logic [31:0] ovf;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [14];

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic check_all(input string name, input logic [31:0] ep, input logic [31:0] pend,
                             input logic [31:0] ovf, input logic [15:0] cnt);
        vectors++;
        if (bus.ep_trigger !== ep || bus.pending !== pend || bus.overflow !== ovf || bus.event_count !== cnt) begin
            miscompares++;
            $display("FAIL %s: got ep=%h pend=%h ovf=%h cnt=%h, required ep=%h pend=%h ovf=%h cnt=%h",
                     name, bus.ep_trigger, bus.pending, bus.overflow, bus.event_count, ep, pend, ovf, cnt);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    initial begin
        // cycle-by-cycle trace on channel 0: rise, repeat (overflow), clear, clear_count, fall
        //         ev      ren      fen      clr cc  ep     pend   ovf    cnt
        tbl[0]  = '{16'h1, 16'h1, 16'h0, 0, 0, 32'h0, 32'h0, 32'h0, 16'd0};
        tbl[1]  = '{16'h1, 16'h1, 16'h0, 0, 0, 32'h0, 32'h0, 32'h0, 16'd0};
        tbl[2]  = '{16'h1, 16'h1, 16'h0, 0, 0, 32'h1, 32'h1, 32'h0, 16'd1};
        tbl[3]  = '{16'h0, 16'h1, 16'h0, 0, 0, 32'h0, 32'h1, 32'h0, 16'd1};
        tbl[4]  = '{16'h0, 16'h1, 16'h0, 0, 0, 32'h0, 32'h1, 32'h0, 16'd1};
        tbl[5]  = '{16'h1, 16'h1, 16'h0, 0, 0, 32'h0, 32'h1, 32'h0, 16'd1};
        tbl[6]  = '{16'h1, 16'h1, 16'h0, 0, 0, 32'h0, 32'h1, 32'h0, 16'd1};
        tbl[7]  = '{16'h1, 16'h1, 16'h0, 0, 0, 32'h1, 32'h1, 32'h1, 16'd2};
        tbl[8]  = '{16'h1, 16'h1, 16'h0, 1, 0, 32'h0, 32'h0, 32'h0, 16'd2};
        tbl[9]  = '{16'h1, 16'h1, 16'h0, 0, 1, 32'h0, 32'h0, 32'h0, 16'd0};
        tbl[10] = '{16'h0, 16'h1, 16'h1, 0, 0, 32'h0, 32'h0, 32'h0, 16'd0};
        tbl[11] = '{16'h0, 16'h1, 16'h1, 0, 0, 32'h0, 32'h0, 32'h0, 16'd0};
        tbl[12] = '{16'h0, 16'h1, 16'h1, 0, 0, 32'h1, 32'h1, 32'h0, 16'd1};
        tbl[13] = '{16'h0, 16'h1, 16'h1, 0, 0, 32'h0, 32'h1, 32'h0, 16'd1};

        bus.event_in    = '0;
        bus.rise_en     = 16'h0001;
        bus.fall_en     = '0;
        bus.holdoff     = '0;
        bus.clear       = '0;
        bus.clear_count = 1'b0;

        step();
        step();
        check_all("reset_state", 32'h0, 32'h0, 32'h0, 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            bus.event_in    = tbl[i].ev;
            bus.rise_en     = tbl[i].ren;
            bus.fall_en     = tbl[i].fen;
            bus.clear       = {15'd0, tbl[i].clr0};
            bus.clear_count = tbl[i].cc;
            step();
            check_all($sformatf("vec%0d", i), tbl[i].ep, tbl[i].pend, tbl[i].ovf, tbl[i].cnt);
        end
        bus.clear       = '0;
        bus.clear_count = 1'b0;

        // channel 5: build pending+overflow, then clear coincident with a new acceptance
        bus.fall_en  = '0;
        bus.rise_en  = 16'h0020;
        bus.event_in = 16'h0020;
        step(); step(); step();
        check_all("ch5_first", 32'h20, 32'h21, 32'h0, 16'd2);
        bus.event_in = 16'h0000;
        step(); step(); step();
        bus.event_in = 16'h0020;
        step(); step(); step();
        check_all("ch5_second", 32'h20, 32'h21, 32'h20, 16'd3);
        bus.event_in = 16'h0000;
        step(); step(); step();
        bus.event_in = 16'h0020;
        step(); step();
        bus.clear = 16'h0020;
        step();
        check_all("ch5_clear_vs_event", 32'h20, 32'h21, 32'h0, 16'd4);
        bus.clear = '0;
        step();
        check_all("ch5_pulse_end", 32'h0, 32'h21, 32'h0, 16'd4);

        // channel 3: toggling every cycle with holdoff=2 gives one acceptance per 3 cycles
        bus.event_in = 16'h0000;
        bus.clear    = 16'hFFFF;
        step();
        bus.clear       = '0;
        bus.rise_en     = 16'h0008;
        bus.fall_en     = 16'h0008;
        bus.holdoff     = 8'd2;
        bus.clear_count = 1'b1;
        step();
        bus.clear_count = 1'b0;
        for (int j = 0; j < 30; j++) begin
            bus.event_in = (j % 2 == 0) ? 16'h0008 : 16'h0000;
            step();
            check_bit($sformatf("holdoff_ep3_cycle%0d", j), bus.ep_trigger[3], (j >= 2) && ((j - 2) % 3 == 0));
        end
        vectors++;
        if (bus.event_count !== 16'd10) begin
            miscompares++;
            $display("FAIL holdoff_count: got %0d, required 10", bus.event_count);
        end
        bus.rise_en = '0;
        bus.fall_en = '0;
        bus.holdoff = '0;
        for (int j = 0; j < 6; j++) step();
        bus.clear = 16'hFFFF;
        step();
        bus.clear = '0;

        // saturation: 16 channels at once with holdoff=0
        bus.rise_en     = 16'hFFFF;
        bus.clear_count = 1'b1;
        step();
        bus.clear_count = 1'b0;
        check_all("sat_start", 32'h0, 32'h0, 32'h0, 16'd0);
        for (int j = 0; j < 4095; j++) begin
            bus.event_in = 16'hFFFF;
            step();
            bus.event_in = 16'h0000;
            step();
        end
        step(); step(); step();
        check_all("sat_4095_events", 32'h0, 32'h0000FFFF, 32'h0000FFFF, 16'hFFF0);
        bus.event_in = 16'hFFFF;
        step();
        bus.event_in = 16'h0000;
        step(); step();
        check_all("sat_4096th_event", 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 16'hFFFF);
        bus.event_in = 16'hFFFF;
        step(); step(); step();
        check_all("sat_stays", 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 16'hFFFF);
        bus.event_in = 16'h0000;
        step(); step(); step();
        bus.event_in = 16'hFFFF;
        step(); step();
        bus.clear_count = 1'b1;
        step();
        check_all("clear_count_vs_event", 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 16'd16);
        step();
        bus.clear_count = 1'b0;
        check_all("clear_count_zero", 32'h0, 32'h0000FFFF, 32'h0000FFFF, 16'd0);

        // async reset during a pulse and a running holdoff window
        bus.event_in = 16'h0000;
        bus.rise_en  = 16'h0002;
        bus.holdoff  = 8'd200;
        bus.clear    = 16'hFFFF;
        step(); step(); step();
        bus.clear    = '0;
        bus.event_in = 16'h0002;
        step(); step(); step();
        check_all("pre_reset_pulse", 32'h2, 32'h2, 32'h0, 16'd1);
        #2;
        reset        = 1'b1;
        bus.event_in = 16'h0004;
        bus.rise_en  = 16'h0004;
        #1;
        check_all("async_reset", 32'h0, 32'h0, 32'h0, 16'd0);
        step(); step();
        reset = 1'b0;
        step();
        check_all("release_edge1", 32'h0, 32'h0, 32'h0, 16'd0);
        step();
        check_all("release_edge2", 32'h0, 32'h0, 32'h0, 16'd0);
        step();
        check_all("release_edge3", 32'h4, 32'h4, 32'h0, 16'd1);
        step();
        check_all("release_edge4", 32'h0, 32'h4, 32'h0, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
